demux_stream_param: RTL and testbench

//  Registered, flow-controlled 1-to-N demultiplexer for the cryo-CMOS control pipeline.

---
 rtl/cryo_pipe_pkg.sv | 14 +
 rtl/demux_slot.sv | 31 +++
 rtl/demux_stream_param.sv | 78 +++++++
 tb/tb_demux_stream_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cryo_pipe_pkg.sv
// Shared definitions for the cryo-CMOS control pipeline.
// Counter width defaults and target decode helpers.
package cryo_pipe_pkg;

  localparam int DEMUX_CNT_WIDTH = 8;

  function automatic logic onehot_bit(
    input logic [31:0] idx,
    input logic [31:0] ch
  );
    return idx == ch;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot for a demux channel.
// Loads on request, drains on consumer ready, reports free.
module demux_slot #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);

  assign free = !valid || ready;

  // Load wins over drain so a full slot refills without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_param.sv
// Registered valid/ready 1-to-N demultiplexer with broadcast
// mask, per-channel one-entry slots and drop accounting.
module demux_stream_param
  import cryo_pipe_pkg::*;
#(
  parameter int NUM_OUTPUT = 15,
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = DEMUX_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [SEL_WIDTH-1:0]             in_sel,
  input  logic                             in_bcast,
  input  logic [NUM_OUTPUT-1:0]            in_mask,
  output logic [NUM_OUTPUT-1:0]            out_valid,
  input  logic [NUM_OUTPUT-1:0]            out_ready,
  output logic [DATA_WIDTH*NUM_OUTPUT-1:0] out_data,
  output logic                             drop_pulse,
  output logic [CNT_WIDTH-1:0]             drop_count
);

  if (NUM_OUTPUT < 1 || NUM_OUTPUT > 2**SEL_WIDTH) begin : g_bad_cfg
    $error("demux_stream_param: NUM_OUTPUT out of range");
  end

  logic [NUM_OUTPUT-1:0] uni;
  logic [NUM_OUTPUT-1:0] target;
  logic [NUM_OUTPUT-1:0] free;
  logic [NUM_OUTPUT-1:0] load;
  logic                  accept;
  logic                  drop;

  // Out-of-range selects match no channel and decode to zero.
  always_comb begin
    uni = '0;
    for (int i = 0; i < NUM_OUTPUT; i++) begin
      uni[i] = onehot_bit(32'(in_sel), 32'(i));
    end
  end

  assign target   = in_bcast ? in_mask : uni;
  assign in_ready = &(~target | free);
  assign accept   = in_valid && in_ready;
  assign load     = accept ? target : '0;
  assign drop     = accept && (target == '0);

  for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .ready     (out_ready[g]),
      .valid     (out_valid[g]),
      .data      (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .free      (free[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_param.sv
// Scoreboard bench for demux_stream_param: per-channel
// expected queues fed on accept, checked by a negedge monitor.
module tb_demux_stream_param;

  localparam int N  = 15;
  localparam int SW = 4;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic          in_bcast;
  logic [N-1:0]  in_mask;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW*N-1:0] out_data;
  logic          drop_pulse;
  logic [CW-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] expq [N][$];
  logic [DW-1:0] last [N];
  int            drops;
  logic          exp_pulse;

  always #5 clk = ~clk;

  demux_stream_param #(
    .NUM_OUTPUT (N),
    .SEL_WIDTH  (SW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] tgt(input logic b,
                                       input logic [N-1:0] m,
                                       input logic [SW-1:0] s);
    logic [N-1:0] one;
    one = 1;
    if (b) return m;
    if (int'(s) < N) return one << s;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      last[i] = '0;
    end
    drops = 0;
    exp_pulse = 1'b0;
  endtask

  // Monitor: compare DUT against the model, then advance the model
  // by the transfers that happen at the coming rising edge.
  initial begin
    logic [N-1:0] t;
    logic rdy;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        continue;
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("valid[%0d]", i), 64'(out_valid[i]),
            64'(expq[i].size() != 0));
        chk($sformatf("data[%0d]", i), 64'(out_data[i*DW +: DW]),
            64'(last[i]));
      end
      t = tgt(in_bcast, in_mask, in_sel);
      rdy = 1'b1;
      for (int i = 0; i < N; i++)
        if (t[i] && expq[i].size() != 0 && !out_ready[i]) rdy = 1'b0;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("drop_pulse", 64'(drop_pulse), 64'(exp_pulse));
      chk("drop_count", 64'(drop_count),
          64'(drops > 255 ? 255 : drops));
      for (int i = 0; i < N; i++) begin
        if (expq[i].size() != 0 && out_ready[i]) begin
          chk($sformatf("deliver[%0d]", i),
              64'(out_data[i*DW +: DW]), 64'(expq[i][0]));
          void'(expq[i].pop_front());
        end
      end
      exp_pulse = 1'b0;
      if (in_valid && rdy) begin
        if (t == '0) begin
          drops++;
          exp_pulse = 1'b1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (t[i]) begin
              expq[i].push_back(in_data);
              last[i] = in_data;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic [N-1:0] m,
                      input logic [SW-1:0] s, input logic [DW-1:0] d);
    int n;
    n = 0;
    in_bcast = b;
    in_mask  = m;
    in_sel   = s;
    in_data  = d;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accept");
        break;
      end
      @(posedge clk);
      #1;
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] one;
    logic acc;
    int cnt;
    one = 1;
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    in_sel    = '0;
    in_mask   = '0;
    in_data   = '0;
    out_ready = '1;

    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(drop_count), 64'(0));
    chk("rst_pulse", 64'(drop_pulse), 64'(0));
    step();
    rst_n = 1'b1;

    // sweep unicast
    for (int s = 0; s < N; s++) begin
      send(1'b0, '0, SW'(s), 4'hA);
      @(negedge clk);
      chk("t1_onehot", 64'(out_valid), 64'(one << s));
      chk("t1_data", 64'(out_data[s*DW +: DW]), 64'hA);
      step();
    end
    chk("t1_count", 64'(drop_count), 64'(0));

    // stall on a full slot, then same-cycle drain and reload
    out_ready[3] = 1'b0;
    send(1'b0, '0, 4'd3, 4'h5);
    in_sel = 4'd3; in_data = 4'h6; in_valid = 1'b1;
    @(negedge clk);
    chk("t2_stall", 64'(in_ready), 64'(0));
    chk("t2_hold", 64'(out_data[12 +: 4]), 64'h5);
    step();
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk("t2_go", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_valid", 64'(out_valid[3]), 64'(1));
    chk("t2_data", 64'(out_data[12 +: 4]), 64'h6);
    step();

    // broadcast is all-or-nothing
    out_ready = '1;
    out_ready[4] = 1'b0;
    send(1'b0, '0, 4'd4, 4'h9);
    in_bcast = 1'b1; in_mask = 15'h0011; in_data = 4'hC;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t3_stall", 64'(in_ready), 64'(0));
    chk("t3_slot0", 64'(out_valid[0]), 64'(0));
    step();
    out_ready[4] = 1'b1;
    @(negedge clk);
    chk("t3_go", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    @(negedge clk);
    chk("t3_valid", 64'(out_valid & 15'h0011), 64'h0011);
    chk("t3_d0", 64'(out_data[0 +: 4]), 64'hC);
    chk("t3_d4", 64'(out_data[16 +: 4]), 64'hC);
    step();

    // out-of-range select: drops saturate
    in_sel = 4'd15; in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_count", 64'(drop_count), 64'd255);
    chk("t4_pulse", 64'(drop_pulse), 64'(1));
    step();

    // a stalled channel does not throttle another
    out_ready = '1;
    out_ready[7] = 1'b0;
    send(1'b0, '0, 4'd7, 4'hE);
    in_sel = 4'd2; in_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      in_data = DW'(k);
      @(negedge clk);
      if (in_ready) cnt++;
      step();
    end
    in_valid = 1'b0;
    chk("t5_tput", 64'(cnt), 64'd20);
    @(negedge clk);
    chk("t5_hold7", 64'(out_data[28 +: 4]), 64'hE);
    step();

    // asynchronous reset mid-stream
    out_ready = '0;
    send(1'b0, '0, 4'd1, 4'h1);
    send(1'b0, '0, 4'd2, 4'h2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_data", 64'(out_data), 64'(0));
    chk("t6_count", 64'(drop_count), 64'(0));
    @(negedge clk);
    step();
    rst_n = 1'b1;
    out_ready = '1;
    send(1'b0, '0, 4'd6, 4'h7);
    @(negedge clk);
    chk("t6_resume", 64'(out_valid), 64'(one << 6));
    chk("t6_rdata", 64'(out_data[24 +: 4]), 64'h7);
    step();

    // randomized traffic against the model
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = N'($urandom);
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_bcast = $urandom_range(0, 4) == 0;
        in_mask  = N'($urandom);
        in_sel   = SW'($urandom_range(0, 15));
        in_data  = DW'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0;
    out_ready = '1;
    repeat (3) step();
    @(negedge clk);
    chk("final_empty", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
